// File: rtl/uart_rx_port_arbiter.sv
// Collects frames from NUM_CH UART receivers into one-entry holding registers and
// serves them round-robin on a single valid/ready output, with overrun and drop stats.
module uart_rx_port_arbiter #(
  parameter int  NUM_CH   = 4,
  parameter int  DATA_W   = 8,
  parameter bit  DROP_ERR = 1'b0,
  localparam int CH_W     = $clog2(NUM_CH)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_CH-1:0]        ch_enable,
  input  logic [NUM_CH*DATA_W-1:0] rx_data,
  input  logic [NUM_CH-1:0]        rx_valid,
  input  logic [NUM_CH-1:0]        rx_par_err,
  input  logic [NUM_CH-1:0]        rx_stp_err,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_par_err,
  output logic                     out_stp_err,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH-1:0]        overrun,
  output logic [7:0]               drop_cnt,
  input  logic                     stat_clr
);

  localparam int             CNT_W      = $clog2(NUM_CH + 1);
  localparam logic [CH_W:0]  NUM_CH_EXT = (CH_W + 1)'(NUM_CH);

  logic [DATA_W-1:0] hold_data [NUM_CH];
  logic [NUM_CH-1:0] hold_par;
  logic [NUM_CH-1:0] hold_stp;
  logic [NUM_CH-1:0] full_reg;
  logic [NUM_CH-1:0] full_next;

  logic [NUM_CH-1:0] accept;
  logic [NUM_CH-1:0] err_drop;
  logic [NUM_CH-1:0] ovr_evt;
  logic [NUM_CH-1:0] store;
  logic [NUM_CH-1:0] granted;

  logic [CH_W-1:0]   rr_ptr_reg;
  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic [CH_W-1:0]   out_ch_reg;
  logic              out_par_reg;
  logic              out_stp_reg;
  logic [NUM_CH-1:0] overrun_reg;
  logic [7:0]        drop_cnt_reg;
  logic [7:0]        drop_cnt_next;

  logic              load_slot;
  logic              grant_vld;
  logic [CH_W-1:0]   grant_idx;
  logic [CH_W:0]     cand;
  logic [CNT_W-1:0]  drop_inc;
  logic [8:0]        drop_sum;

  // Walk from the farthest candidate to the nearest so the channel right after rr_ptr wins.
  always_comb begin
    load_slot = !out_valid_reg || out_ready;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = {1'b0, rr_ptr_reg} + (CH_W + 1)'(k);
      if (cand >= NUM_CH_EXT) begin
        cand = cand - NUM_CH_EXT;
      end
      if (load_slot && full_reg[cand[CH_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[CH_W-1:0];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DATA_W-1:0] data_reg;
      logic              par_reg;
      logic              stp_reg;

      assign accept[gi]   = rx_valid[gi] & ch_enable[gi];
      assign err_drop[gi] = accept[gi] & DROP_ERR & (rx_par_err[gi] | rx_stp_err[gi]);
      assign granted[gi]  = grant_vld && (grant_idx == CH_W'(gi));
      // A slot being emptied by this cycle's grant can take the new frame without loss.
      assign ovr_evt[gi]  = accept[gi] & ~err_drop[gi] & full_reg[gi] & ~granted[gi];
      assign store[gi]    = accept[gi] & ~err_drop[gi] & ~ovr_evt[gi];
      assign full_next[gi] = store[gi] ? 1'b1 : (granted[gi] ? 1'b0 : full_reg[gi]);

      always_ff @(posedge CLK) begin
        if (store[gi]) begin
          data_reg <= rx_data[gi*DATA_W +: DATA_W];
          par_reg  <= rx_par_err[gi];
          stp_reg  <= rx_stp_err[gi];
        end
      end

      assign hold_data[gi] = data_reg;
      assign hold_par[gi]  = par_reg;
      assign hold_stp[gi]  = stp_reg;
    end
  endgenerate

  always_comb begin
    drop_inc = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      drop_inc = drop_inc + CNT_W'(err_drop[i] | ovr_evt[i]);
    end
    drop_sum      = {1'b0, drop_cnt_reg} + 9'(drop_inc);
    drop_cnt_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      full_reg      <= '0;
      rr_ptr_reg    <= CH_W'(NUM_CH - 1);
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
      out_par_reg   <= 1'b0;
      out_stp_reg   <= 1'b0;
      overrun_reg   <= '0;
      drop_cnt_reg  <= '0;
    end else begin
      full_reg <= full_next;
      if (grant_vld) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= hold_data[grant_idx];
        out_ch_reg    <= grant_idx;
        out_par_reg   <= hold_par[grant_idx];
        out_stp_reg   <= hold_stp[grant_idx];
        rr_ptr_reg    <= grant_idx;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
      if (stat_clr) begin
        overrun_reg  <= '0;
        drop_cnt_reg <= '0;
      end else begin
        overrun_reg  <= overrun_reg | ovr_evt;
        drop_cnt_reg <= drop_cnt_next;
      end
    end
  end

  assign out_valid   = out_valid_reg;
  assign out_data    = out_data_reg;
  assign out_ch      = out_ch_reg;
  assign out_par_err = out_par_reg;
  assign out_stp_err = out_stp_reg;
  assign overrun     = overrun_reg;
  assign drop_cnt    = drop_cnt_reg;

endmodule

// File: tb/tb_uart_rx_port_arbiter.sv
// Directed bench for uart_rx_port_arbiter: a per-cycle vector table plus hand-written
// sequences for backpressure, same-cycle recapture, saturation, reset and error dropping.
module tb_uart_rx_port_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  ch_enable;
  logic [31:0] rx_data;
  logic [3:0]  rx_valid;
  logic [3:0]  rx_par_err;
  logic [3:0]  rx_stp_err;
  logic        out_ready;
  logic        stat_clr;

  logic [7:0]  out_data, out_data_d1;
  logic [1:0]  out_ch, out_ch_d1;
  logic        out_par_err, out_par_err_d1;
  logic        out_stp_err, out_stp_err_d1;
  logic        out_valid, out_valid_d1;
  logic [3:0]  overrun, overrun_d1;
  logic [7:0]  drop_cnt, drop_cnt_d1;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  uart_rx_port_arbiter #(.NUM_CH(4), .DATA_W(8), .DROP_ERR(1'b0)) u_dut (
    .CLK(CLK), .RST(RST), .ch_enable(ch_enable), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_par_err(rx_par_err), .rx_stp_err(rx_stp_err), .out_data(out_data), .out_ch(out_ch),
    .out_par_err(out_par_err), .out_stp_err(out_stp_err), .out_valid(out_valid),
    .out_ready(out_ready), .overrun(overrun), .drop_cnt(drop_cnt), .stat_clr(stat_clr)
  );

  uart_rx_port_arbiter #(.NUM_CH(4), .DATA_W(8), .DROP_ERR(1'b1)) u_dut_drop (
    .CLK(CLK), .RST(RST), .ch_enable(ch_enable), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_par_err(rx_par_err), .rx_stp_err(rx_stp_err), .out_data(out_data_d1), .out_ch(out_ch_d1),
    .out_par_err(out_par_err_d1), .out_stp_err(out_stp_err_d1), .out_valid(out_valid_d1),
    .out_ready(out_ready), .overrun(overrun_d1), .drop_cnt(drop_cnt_d1), .stat_clr(stat_clr)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  en;
    logic [3:0]  vld;
    logic [31:0] data;
    logic [3:0]  par;
    logic [3:0]  stp;
    logic        rdy;
    logic        e_vld;
    logic [7:0]  e_data;
    logic [1:0]  e_ch;
    logic        e_par;
    logic        e_stp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic [3:0] en, logic [3:0] vld, logic [31:0] data,
                              logic [3:0] par, logic [3:0] stp, logic e_vld, logic [7:0] e_data,
                              logic [1:0] e_ch, logic e_par, logic e_stp);
    vec_t v;
    v.rst = rst; v.en = en; v.vld = vld; v.data = data; v.par = par; v.stp = stp;
    v.rdy = 1'b1; v.e_vld = e_vld; v.e_data = e_data; v.e_ch = e_ch;
    v.e_par = e_par; v.e_stp = e_stp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ch_enable  = 4'hF;
    rx_valid   = 4'h0;
    rx_data    = 32'h0;
    rx_par_err = 4'h0;
    rx_stp_err = 4'h0;
    stat_clr   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1'b0;
    tick();
    RST = 1'b1;
  endtask

  initial begin
    RST       = 1'b1;
    out_ready = 1'b1;
    idle_inputs();

    // reset, single frame on ch2
    vecs.push_back(mk(1, 4'hF, 4'h0, 32'h0,        4'h0, 4'h0, 0, 8'h00, 2'd0, 0, 0));
    vecs.push_back(mk(0, 4'hF, 4'h4, 32'h00A50000, 4'h0, 4'h0, 0, 8'h00, 2'd0, 0, 0));
    vecs.push_back(mk(0, 4'hF, 4'h0, 32'h0,        4'h0, 4'h0, 1, 8'hA5, 2'd2, 0, 0));
    vecs.push_back(mk(0, 4'hF, 4'h0, 32'h0,        4'h0, 4'h0, 0, 8'h00, 2'd0, 0, 0));
    // round robin from reset pointer: 0,1,2,3
    vecs.push_back(mk(1, 4'hF, 4'h0, 32'h0,        4'h0, 4'h0, 0, 8'h00, 2'd0, 0, 0));
    vecs.push_back(mk(0, 4'hF, 4'hF, 32'h13121110, 4'h0, 4'h0, 0, 8'h00, 2'd0, 0, 0));
    vecs.push_back(mk(0, 4'hF, 4'h0, 32'h0,        4'h0, 4'h0, 1, 8'h10, 2'd0, 0, 0));
    vecs.push_back(mk(0, 4'hF, 4'h0, 32'h0,        4'h0, 4'h0, 1, 8'h11, 2'd1, 0, 0));
    vecs.push_back(mk(0, 4'hF, 4'h0, 32'h0,        4'h0, 4'h0, 1, 8'h12, 2'd2, 0, 0));
    vecs.push_back(mk(0, 4'hF, 4'h0, 32'h0,        4'h0, 4'h0, 1, 8'h13, 2'd3, 0, 0));
    vecs.push_back(mk(0, 4'hF, 4'h0, 32'h0,        4'h0, 4'h0, 0, 8'h00, 2'd0, 0, 0));
    // ch1 grant leaves rr_ptr=1, then all four: 2,3,0,1
    vecs.push_back(mk(0, 4'hF, 4'h2, 32'h00002100, 4'h0, 4'h0, 0, 8'h00, 2'd0, 0, 0));
    vecs.push_back(mk(0, 4'hF, 4'h0, 32'h0,        4'h0, 4'h0, 1, 8'h21, 2'd1, 0, 0));
    vecs.push_back(mk(0, 4'hF, 4'hF, 32'h33323130, 4'h0, 4'h0, 0, 8'h00, 2'd0, 0, 0));
    vecs.push_back(mk(0, 4'hF, 4'h0, 32'h0,        4'h0, 4'h0, 1, 8'h32, 2'd2, 0, 0));
    vecs.push_back(mk(0, 4'hF, 4'h0, 32'h0,        4'h0, 4'h0, 1, 8'h33, 2'd3, 0, 0));
    vecs.push_back(mk(0, 4'hF, 4'h0, 32'h0,        4'h0, 4'h0, 1, 8'h30, 2'd0, 0, 0));
    vecs.push_back(mk(0, 4'hF, 4'h0, 32'h0,        4'h0, 4'h0, 1, 8'h31, 2'd1, 0, 0));
    vecs.push_back(mk(0, 4'hF, 4'h0, 32'h0,        4'h0, 4'h0, 0, 8'h00, 2'd0, 0, 0));
    // errored frames forwarded with flags
    vecs.push_back(mk(0, 4'hF, 4'h8, 32'h81000000, 4'h8, 4'h0, 0, 8'h00, 2'd0, 0, 0));
    vecs.push_back(mk(0, 4'hF, 4'h0, 32'h0,        4'h0, 4'h0, 1, 8'h81, 2'd3, 1, 0));
    vecs.push_back(mk(0, 4'hF, 4'h4, 32'h00420000, 4'h0, 4'h4, 0, 8'h00, 2'd0, 0, 0));
    vecs.push_back(mk(0, 4'hF, 4'h0, 32'h0,        4'h0, 4'h0, 1, 8'h42, 2'd2, 0, 1));
    // pulse on disabled ch0 produces nothing
    vecs.push_back(mk(0, 4'hE, 4'h1, 32'h00000099, 4'h0, 4'h0, 0, 8'h00, 2'd0, 0, 0));
    vecs.push_back(mk(0, 4'hF, 4'h0, 32'h0,        4'h0, 4'h0, 0, 8'h00, 2'd0, 0, 0));
    vecs.push_back(mk(0, 4'hF, 4'h0, 32'h0,        4'h0, 4'h0, 0, 8'h00, 2'd0, 0, 0));

    foreach (vecs[i]) begin
      RST        = !vecs[i].rst;
      ch_enable  = vecs[i].en;
      rx_valid   = vecs[i].vld;
      rx_data    = vecs[i].data;
      rx_par_err = vecs[i].par;
      rx_stp_err = vecs[i].stp;
      out_ready  = vecs[i].rdy;
      tick();
      chk($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].e_vld));
      if (vecs[i].e_vld || vecs[i].rst) begin
        chk($sformatf("v%0d.out_data", i), 32'(out_data), 32'(vecs[i].e_data));
        chk($sformatf("v%0d.out_ch", i), 32'(out_ch), 32'(vecs[i].e_ch));
        chk($sformatf("v%0d.out_par_err", i), 32'(out_par_err), 32'(vecs[i].e_par));
        chk($sformatf("v%0d.out_stp_err", i), 32'(out_stp_err), 32'(vecs[i].e_stp));
      end
      chk($sformatf("v%0d.overrun", i), 32'(overrun), 32'h0);
      chk($sformatf("v%0d.drop_cnt", i), 32'(drop_cnt), 32'h0);
    end
    RST = 1'b1;
    idle_inputs();

    // backpressure on ch1 with a held second frame and an overrunning third
    do_reset();
    out_ready = 1'b0;
    rx_valid = 4'h2; rx_data = 32'h00003C00;
    tick();
    rx_valid = 4'h0;
    chk("bp.first_valid", 32'(out_valid), 32'h0);
    tick();
    chk("bp.present_valid", 32'(out_valid), 32'h1);
    chk("bp.present_data", 32'(out_data), 32'h3C);
    rx_valid = 4'h2; rx_data = 32'h00005500;
    tick();
    rx_valid = 4'h0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        rx_valid = 4'h2; rx_data = 32'h00007700;
      end
      tick();
      rx_valid = 4'h0;
      chk($sformatf("bp.hold%0d", i), {out_valid, 21'h0, out_ch, out_data},
          {1'b1, 21'h0, 2'd1, 8'h3C});
    end
    chk("bp.overrun", 32'(overrun), 32'h2);
    chk("bp.drop_cnt", 32'(drop_cnt), 32'h1);
    out_ready = 1'b1;
    tick();
    chk("bp.second_valid", 32'(out_valid), 32'h1);
    chk("bp.second_data", {22'h0, out_ch, out_data}, {22'h0, 2'd1, 8'h55});
    tick();
    chk("bp.drained", 32'(out_valid), 32'h0);
    chk("bp.overrun_sticky", 32'(overrun), 32'h2);

    // ch0 recaptured in the cycle its held frame is granted
    do_reset();
    out_ready = 1'b1;
    rx_valid = 4'h1; rx_data = 32'h00000011;
    tick();
    rx_data = 32'h00000022;
    tick();
    rx_valid = 4'h0;
    chk("same.first", {23'h0, out_valid, out_data}, {23'h0, 1'b1, 8'h11});
    tick();
    chk("same.second", {23'h0, out_valid, out_data}, {23'h0, 1'b1, 8'h22});
    tick();
    chk("same.drained", 32'(out_valid), 32'h0);
    chk("same.overrun", 32'(overrun), 32'h0);
    chk("same.drop_cnt", 32'(drop_cnt), 32'h0);

    // 300 overruns saturate drop_cnt, stat_clr wins over a same-cycle overrun
    do_reset();
    out_ready = 1'b0;
    rx_valid = 4'h1; rx_data = 32'h00000001;
    for (int i = 0; i < 302; i++) begin
      tick();
    end
    chk("sat.drop_cnt", 32'(drop_cnt), 32'd255);
    chk("sat.overrun", 32'(overrun), 32'h1);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("clr.drop_cnt", 32'(drop_cnt), 32'h0);
    chk("clr.overrun", 32'(overrun), 32'h0);
    tick();
    rx_valid = 4'h0;
    chk("clr.next_drop", 32'(drop_cnt), 32'h1);
    chk("clr.next_overrun", 32'(overrun), 32'h1);
    chk("rst.pre_valid", 32'(out_valid), 32'h1);
    RST = 1'b0;
    tick();
    chk("rst.out_valid", 32'(out_valid), 32'h0);
    chk("rst.drop_cnt", 32'(drop_cnt), 32'h0);
    chk("rst.overrun", 32'(overrun), 32'h0);
    RST = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst.full_flushed", 32'(out_valid), 32'h0);

    // parity-error frame: forwarded without filter, dropped with filter
    do_reset();
    out_ready = 1'b1;
    rx_valid = 4'h8; rx_data = 32'h81000000; rx_par_err = 4'h8;
    tick();
    idle_inputs();
    chk("drop.d1_drop_cnt", 32'(drop_cnt_d1), 32'h1);
    chk("drop.d0_drop_cnt", 32'(drop_cnt), 32'h0);
    tick();
    chk("drop.d1_valid", 32'(out_valid_d1), 32'h0);
    chk("drop.d0_frame", {22'h0, out_valid, out_par_err, out_data}, {22'h0, 1'b1, 1'b1, 8'h81});
    tick();
    chk("drop.d1_valid_late", 32'(out_valid_d1), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_port_arbiter.md
Name: uart_rx_port_arbiter

Overview:
Shares one downstream byte consumer among NUM_CH independent UART receiver instances. Each receiver produces single-cycle data_valid pulses with P_DATA, Parity_Error and Stop_Error. This block captures every frame into a per-channel one-entry holding register. It then presents frames one at a time on a single valid/ready output, using round-robin arbitration. It also detects overruns and can optionally filter errored frames. It sits between the bank of receivers and the host/register interface.

Parameters:
NUM_CH, 4, number of receiver channels (2..16)
DATA_W, 8, frame data width
CH_W, $clog2(NUM_CH), channel index width (derived, not overridable)
DROP_ERR, 0, 1 = discard frames with parity or stop error at capture; 0 = forward them with flags

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  reset, synchronous, active-low
ch_enable  in  NUM_CH  per-channel capture enable
rx_data  in  NUM_CH*DATA_W  channel i data at [i*DATA_W +: DATA_W]
rx_valid  in  NUM_CH  single-cycle frame-valid pulse per channel
rx_par_err  in  NUM_CH  parity error qualifier, sampled with rx_valid
rx_stp_err  in  NUM_CH  stop error qualifier, sampled with rx_valid
out_data  out  DATA_W  granted frame data
out_ch  out  CH_W  source channel of out_data
out_par_err  out  1  parity error flag of presented frame
out_stp_err  out  1  stop error flag of presented frame
out_valid  out  1  output frame valid
out_ready  in  1  consumer accepts when out_valid && out_ready
overrun  out  NUM_CH  sticky per-channel overrun flag
drop_cnt  out  8  saturating count of dropped frames (overrun + DROP_ERR filter)
stat_clr  in  1  clears overrun and drop_cnt

Behaviour:
- Reset (RST=0 at clock edge): all holding-register full flags = 0; out_valid = 0; out_data, out_ch, out_par_err, out_stp_err = 0; overrun = 0; drop_cnt = 0; rr_ptr = NUM_CH-1, so channel 0 wins first. Reset mid-transfer discards all held and presented frames.
- Capture, channel i: when rx_valid[i] && ch_enable[i], store data and both flags, and set full[i] next cycle.
  - If ch_enable[i]=0, the pulse is ignored. It is not counted and does not set overrun.
  - If DROP_ERR=1 and (rx_par_err[i] | rx_stp_err[i]), the frame is not stored and drop_cnt increments.
- Overrun: rx_valid[i] accepted while full[i]=1 and channel i is not being granted in the same cycle.
  - The held frame is kept and the new frame is discarded.
  - overrun[i] is set and drop_cnt increments.
- Simultaneous grant and capture on the same channel: the new frame is stored, full[i] stays 1, and there is no overrun.
- Arbitration: a load slot exists when out_valid=0 or (out_valid && out_ready).
  - In a load slot, grant the first i with full[i]=1, searching from rr_ptr+1 upward with wrap modulo NUM_CH.
  - On grant: out_* are loaded from holding register i at the next edge, out_valid=1, full[i] cleared (unless recaptured per the rule above), rr_ptr=i.
  - If nothing is full, out_valid drops to 0 after a handshake.
- Output stability: while out_valid && !out_ready, out_data, out_ch and the flags hold constant and no grant occurs.
- Throughput: one frame per cycle when out_ready is held high and requests are pending. Back-to-back handshakes require no bubble.
- Latency: rx_valid at edge N sets full at N+1. If the output slot is free, out_valid=1 at N+2.
- Disabling a channel does not flush its held frame; the frame is still granted.
- drop_cnt saturates at 255.
  - stat_clr=1 clears overrun and drop_cnt. It wins over a same-cycle increment or set; that event is lost.
- Multiple channels may overrun or drop in the same cycle. drop_cnt increments by the number of drops that cycle, saturating.
- Arbiter state: rr_ptr register plus output register. No other FSM states are needed beyond the full flags and out_valid.

Test Plan:
- Single frame: ch2 rx_valid with 0xA5, out_ready=1. Required: out_valid=1 two cycles later, out_data=0xA5, out_ch=2, flags 0; out_valid=0 next cycle.
- Round-robin: ch0..ch3 pulse in the same cycle, out_ready=1. Required: grants in order 0,1,2,3 on consecutive cycles. Repeat with rr_ptr=1 after a prior ch1 grant; required order 2,3,0,1.
- Backpressure: out_ready=0 for 10 cycles with ch1=0x3C presented and ch1 receiving 0x55. Required: output stays 0x3C/ch1. A third ch1 frame sets overrun[1]=1 and drop_cnt=1. After release, 0x3C then 0x55.
- Same-cycle grant and capture: ch0 held frame granted in the same cycle a new ch0 frame arrives. Required: no overrun; both frames delivered in order.
- Error filtering: with DROP_ERR=0, a parity-error frame 0x81 on ch3 is forwarded with out_par_err=1. With DROP_ERR=1 it is not forwarded and drop_cnt increments by 1. A disabled channel pulse produces nothing.
- Reset and saturation: 300 overruns give drop_cnt=255. stat_clr zeroes drop_cnt and overrun. Asserting RST low during out_valid=1 gives out_valid=0 and all full flags cleared on the next edge.
